// File: rtl/doc_uart_streamer.sv
// Streams the character document row by row out of a UART transmitter.
// Trailing blank cells can be trimmed, and every row ends with CR LF.
module doc_uart_streamer #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ROW_W        = 4,
    parameter int         COL_W        = 5,
    parameter int         ROWS         = 15,
    parameter int         COLS         = 20,
    parameter logic [7:0] BLANK        = 8'h00,
    parameter bit         TRIM         = 1'b1,
    parameter int         PARITY       = 0,
    parameter int         STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send,
    input  logic                   abort,
    input  logic [7:0]             read_data,
    output logic                   read_en,
    output logic [ROW_W+COL_W-1:0] read_addr,
    output logic                   RsTx,
    output logic                   busy,
    output logic                   done
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int                FRAME_BITS = 10 + ((PARITY != 0) ? 1 : 0) + (STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST   = 4'(FRAME_BITS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [7:0]        CHR_CR     = 8'h0D;
    localparam logic [7:0]        CHR_LF     = 8'h0A;
    localparam logic [7:0]        CHR_SP     = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_FETCH, S_TX, S_CR, S_LF, S_FINISH
    } state_t;

    state_t           state, state_next;
    logic [ROW_W-1:0] row, row_next;
    logic [COL_W-1:0] col, col_next;
    logic [COL_W-1:0] last, last_next;
    logic [COL_W-1:0] col_end;
    logic [CNT_W-1:0] cyc_cnt;
    logic [3:0]       bit_cnt;
    logic [11:0]      shreg;
    logic             abort_pend;
    logic             abort_req;
    logic             in_frame;
    logic             frame_end;
    logic             load;
    logic [7:0]       load_byte;

    // Full frame image, LSB first on the wire; unused upper bits stay at
    // the idle/stop level so shifting in ones leaves the line high.
    function automatic logic [11:0] build_frame(input logic [7:0] data);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = data;
        if (PARITY == 1)
            f[9] = ^data;
        else if (PARITY == 2)
            f[9] = ~^data;
        return f;
    endfunction

    assign in_frame  = (state == S_TX) || (state == S_CR) || (state == S_LF);
    assign frame_end = in_frame && (cyc_cnt == CNT_LAST) && (bit_cnt == BIT_LAST);
    assign abort_req = abort | abort_pend;
    assign col_end   = TRIM ? last : COL_LAST;

    assign RsTx      = shreg[0];
    assign busy      = (state != S_IDLE);
    assign read_addr = {row, col};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        row_next   = row;
        col_next   = col;
        last_next  = last;
        load       = 1'b0;
        load_byte  = CHR_CR;
        read_en    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (send) begin
                    row_next = '0;
                    if (TRIM) begin
                        col_next   = COL_LAST;
                        state_next = S_SCAN;
                    end else begin
                        col_next   = '0;
                        state_next = S_FETCH;
                    end
                end
            end
            S_SCAN: begin
                read_en = 1'b1;
                if (abort_req) begin
                    state_next = S_IDLE;
                end else if (read_data != BLANK) begin
                    last_next  = col;
                    col_next   = '0;
                    state_next = S_FETCH;
                end else if (col == '0) begin
                    load       = 1'b1;
                    load_byte  = CHR_CR;
                    state_next = S_CR;
                end else begin
                    col_next = col - COL_W'(1);
                end
            end
            S_FETCH: begin
                read_en = 1'b1;
                if (abort_req) begin
                    state_next = S_IDLE;
                end else begin
                    load       = 1'b1;
                    load_byte  = (read_data == BLANK) ? CHR_SP : read_data;
                    state_next = S_TX;
                end
            end
            S_TX: begin
                if (frame_end) begin
                    if (abort_req) begin
                        state_next = S_IDLE;
                    end else if (col == col_end) begin
                        load       = 1'b1;
                        load_byte  = CHR_CR;
                        state_next = S_CR;
                    end else begin
                        col_next   = col + COL_W'(1);
                        state_next = S_FETCH;
                    end
                end
            end
            S_CR: begin
                if (frame_end) begin
                    if (abort_req) begin
                        state_next = S_IDLE;
                    end else begin
                        load       = 1'b1;
                        load_byte  = CHR_LF;
                        state_next = S_LF;
                    end
                end
            end
            S_LF: begin
                if (frame_end) begin
                    if (abort_req) begin
                        state_next = S_IDLE;
                    end else if (row == ROW_LAST) begin
                        state_next = S_FINISH;
                    end else begin
                        row_next   = row + ROW_W'(1);
                        col_next   = TRIM ? COL_LAST : '0;
                        state_next = TRIM ? S_SCAN : S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            last       <= '0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '1;
            abort_pend <= 1'b0;
        end else begin
            state <= state_next;
            row   <= row_next;
            col   <= col_next;
            last  <= last_next;
            // An abort seen while busy is held until the machine parks in IDLE.
            if (state_next == S_IDLE)
                abort_pend <= 1'b0;
            else if (abort && (state != S_IDLE))
                abort_pend <= 1'b1;
            if (load) begin
                shreg   <= build_frame(load_byte);
                cyc_cnt <= '0;
                bit_cnt <= '0;
            end else if (in_frame) begin
                if (cyc_cnt == CNT_LAST) begin
                    cyc_cnt <= '0;
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {1'b1, shreg[11:1]};
                end else begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
